// File: rtl/stopwatch_dp_if.sv
// Signal bundle between the stopwatch control unit, this datapath and the display stage.
// The datapath takes the slave view; the control/display side takes the master view.
interface stopwatch_dp_if;
    logic       runstop;
    logic       clear;
    logic [6:0] msec;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic       tick;

    modport master (
        output runstop, clear,
        input  msec, sec, min, hour, tick
    );

    modport slave (
        input  runstop, clear,
        output msec, sec, min, hour, tick
    );
endinterface

// File: rtl/stopwatch_dp.sv
// Stopwatch datapath: prescaler producing a centisecond tick plus an hh:mm:ss.cc counter cascade.
// Priority per edge is rst > clear > runstop; every output is a register.
module stopwatch_dp #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TICK_HZ     = 100
) (
    input  logic          clk,
    input  logic          rst,
    stopwatch_dp_if.slave sw
);
    localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    logic [PW-1:0] presc_reg, presc_next;
    logic [6:0]    msec_reg,  msec_next;
    logic [5:0]    sec_reg,   sec_next;
    logic [5:0]    min_reg,   min_next;
    logic [4:0]    hour_reg,  hour_next;
    logic          tick_reg,  tick_next;

    always_comb begin
        presc_next = presc_reg;
        msec_next  = msec_reg;
        sec_next   = sec_reg;
        min_next   = min_reg;
        hour_next  = hour_reg;
        tick_next  = 1'b0;
        if (sw.clear) begin
            presc_next = '0;
            msec_next  = '0;
            sec_next   = '0;
            min_next   = '0;
            hour_next  = '0;
        end else if (sw.runstop) begin
            if (presc_reg == PRESC_LAST) begin
                presc_next = '0;
                tick_next  = 1'b1;
                // Each field only looks at its own terminal value; carries ripple in one edge.
                if (msec_reg == 7'd99) begin
                    msec_next = '0;
                    if (sec_reg == 6'd59) begin
                        sec_next = '0;
                        if (min_reg == 6'd59) begin
                            min_next  = '0;
                            hour_next = (hour_reg == 5'd23) ? 5'd0 : hour_reg + 5'd1;
                        end else begin
                            min_next = min_reg + 6'd1;
                        end
                    end else begin
                        sec_next = sec_reg + 6'd1;
                    end
                end else begin
                    msec_next = msec_reg + 7'd1;
                end
            end else begin
                presc_next = presc_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_reg <= '0;
            msec_reg  <= '0;
            sec_reg   <= '0;
            min_reg   <= '0;
            hour_reg  <= '0;
            tick_reg  <= 1'b0;
        end else begin
            presc_reg <= presc_next;
            msec_reg  <= msec_next;
            sec_reg   <= sec_next;
            min_reg   <= min_next;
            hour_reg  <= hour_next;
            tick_reg  <= tick_next;
        end
    end

    assign sw.msec = msec_reg;
    assign sw.sec  = sec_reg;
    assign sw.min  = min_reg;
    assign sw.hour = hour_reg;
    assign sw.tick = tick_reg;
endmodule
